// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and entry type for the hazard scoreboard
//
// Contents:
//   regfile_logsize : register index width
//   SB_NREG         : number of architectural registers (x0 hardwired zero)
//   SB_MAXLAT       : largest fixed latency accepted on issue
//   SB_LATW         : countdown width, wide enough to hold SB_MAXLAT
//   sb_entry_t      : per-register state {pend, cnt}
package hazard_scoreboard_pkg;

    localparam int regfile_logsize = 5;
    localparam int SB_NREG         = 32;
    localparam int SB_MAXLAT       = 7;
    localparam int SB_LATW         = $clog2(SB_MAXLAT + 1);

    // A pending entry with cnt == 0 is a write owned by the variable-latency
    // unit; a pending entry with cnt != 0 is a fixed-latency countdown.
    typedef struct packed {
        logic               pend;
        logic [SB_LATW-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one register's in-flight write tracker
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : pipeline flush, drops any pending write
//   load      : an effective issue targets this register
//   load_var  : the issued write comes from the variable-latency unit
//   load_lat  : fixed latency of the issued write (0 = forwardable next cycle)
//   cmpl_hit  : variable-latency completion addresses this register
//   pend      : register has an unbypassable write in flight
module sb_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               load_var,
    input  logic [SB_LATW-1:0] load_lat,
    input  logic               cmpl_hit,
    output logic               pend
);

    sb_entry_t st;

    // Priority: flush, then issue, then completion, then countdown.
    // Issue is already masked by flush upstream, so the order of those two
    // only matters for robustness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= '0;
        end else if (flush) begin
            st <= '0;
        end else if (load) begin
            if (load_var) begin
                st.pend <= 1'b1;
                st.cnt  <= '0;
            end else begin
                // Zero latency supersedes an older write with nothing pending.
                st.pend <= (load_lat != '0);
                st.cnt  <= load_lat;
            end
        end else if (cmpl_hit && st.pend && (st.cnt == '0)) begin
            st <= '0;
        end else if (st.pend && (st.cnt != '0)) begin
            st.cnt <= st.cnt - 1'b1;
            if (st.cnt == SB_LATW'(1)) begin
                st.pend <= 1'b0;
            end
        end
    end

    assign pend = st.pend;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - tracks unbypassable in-flight writes and stalls dependent decode
//
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   issue_valid/wr/rd/lat/var   : instruction issued from decode and its destination timing
//   cmpl_valid, cmpl_rd         : variable-latency unit result reaches the forwarding point
//   rs1, rs2, rs1_used, rs2_used: source operands of the instruction in decode
//   flush                       : pipeline flush
//   stall                       : hold decode, issue suppressed
//   var_busy                    : a variable-latency write is outstanding
//   pending_mask                : per-register pending flags
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG    = SB_NREG,
    parameter int LOGSIZE = regfile_logsize,
    parameter int MAXLAT  = SB_MAXLAT,
    parameter int LATW    = $clog2(MAXLAT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic               issue_wr,
    input  logic [LOGSIZE-1:0] issue_rd,
    input  logic [LATW-1:0]    issue_lat,
    input  logic               issue_var,
    input  logic               cmpl_valid,
    input  logic [LOGSIZE-1:0] cmpl_rd,
    input  logic [LOGSIZE-1:0] rs1,
    input  logic [LOGSIZE-1:0] rs2,
    input  logic               rs1_used,
    input  logic               rs2_used,
    input  logic               flush,
    output logic               stall,
    output logic               var_busy,
    output logic [NREG-1:0]    pending_mask
);

    logic [NREG-1:0]    pend_vec;
    logic               issue_fire;
    logic               var_v;
    logic [LOGSIZE-1:0] var_rd;

    assign issue_fire = issue_valid & ~stall & ~flush & issue_wr & (issue_rd != '0);

    assign pend_vec[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        sb_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .load     (issue_fire && (issue_rd == LOGSIZE'(i))),
            .load_var (issue_var),
            .load_lat (issue_lat),
            .cmpl_hit (cmpl_valid && (cmpl_rd == LOGSIZE'(i))),
            .pend     (pend_vec[i])
        );
    end

    // Single variable-latency slot. It outlives flushes and WAW overwrites
    // of its register because the unit still writes back; only the
    // completion for var_rd retires it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            var_v  <= 1'b0;
            var_rd <= '0;
        end else if (issue_fire && issue_var) begin
            var_v  <= 1'b1;
            var_rd <= issue_rd;
        end else if (cmpl_valid && var_v && (cmpl_rd == var_rd)) begin
            var_v  <= 1'b0;
        end
    end

    assign var_busy     = var_v;
    assign pending_mask = pend_vec;

    // A second variable-latency issue must wait for the slot to free up.
    assign stall = (rs1_used & (rs1 != '0) & pend_vec[rs1])
                 | (rs2_used & (rs2 != '0) & pend_vec[rs2])
                 | (issue_valid & issue_var & var_v);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_wr = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [2:0]  issue_lat = '0;
    logic        issue_var = 1'b0;
    logic        cmpl_valid = 1'b0;
    logic [4:0]  cmpl_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_used = 1'b0;
    logic        rs2_used = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        var_busy;
    logic [31:0] pending_mask;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_wr     (issue_wr),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .issue_var    (issue_var),
        .cmpl_valid   (cmpl_valid),
        .cmpl_rd      (cmpl_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .flush        (flush),
        .stall        (stall),
        .var_busy     (var_busy),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    // Model: each register holds the absolute cycle at which readers may
    // proceed, plus a flag for writes owned by the variable-latency unit.
    int ready_at [32];
    bit m_var    [32];
    bit m_vbusy = 1'b0;
    int m_vrd   = 0;
    int cyc     = 0;

    function automatic bit m_pend(input int r);
        return (r != 0) && (m_var[r] || (cyc < ready_at[r]));
    endfunction

    function automatic bit m_stall();
        return (rs1_used && m_pend(int'(rs1))) || (rs2_used && m_pend(int'(rs2)))
            || (issue_valid && issue_var && m_vbusy);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        for (int r = 0; r < 32; r++) m[r] = m_pend(r);
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                ready_at[r] = 0;
                m_var[r]    = 1'b0;
            end
            m_vbusy = 1'b0;
        end else begin
            bit eff;
            eff = issue_valid && !m_stall() && !flush && issue_wr && (issue_rd != 0);
            if (cmpl_valid) begin
                if (cmpl_rd != 0) m_var[cmpl_rd] = 1'b0;
                if (m_vbusy && int'(cmpl_rd) == m_vrd) m_vbusy = 1'b0;
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) begin
                    ready_at[r] = 0;
                    m_var[r]    = 1'b0;
                end
            end else if (eff) begin
                if (issue_var) begin
                    m_var[issue_rd]    = 1'b1;
                    ready_at[issue_rd] = 0;
                    m_vbusy            = 1'b1;
                    m_vrd              = int'(issue_rd);
                end else begin
                    m_var[issue_rd]    = 1'b0;
                    ready_at[issue_rd] = cyc + 1 + int'(issue_lat);
                end
            end
            cyc = cyc + 1;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        n_tests = n_tests + 1;
        if (stall !== m_stall()) begin
            n_fail = n_fail + 1;
            $display("FAIL model_stall t=%0t got %b want %b", $time, stall, m_stall());
        end
        n_tests = n_tests + 1;
        if (var_busy !== m_vbusy) begin
            n_fail = n_fail + 1;
            $display("FAIL model_var_busy t=%0t got %b want %b", $time, var_busy, m_vbusy);
        end
        n_tests = n_tests + 1;
        if (pending_mask !== m_mask()) begin
            n_fail = n_fail + 1;
            $display("FAIL model_mask t=%0t got %h want %h", $time, pending_mask, m_mask());
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests = n_tests + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rd, input logic [2:0] lat, input logic isvar);
        issue_valid = v;
        issue_wr    = v;
        issue_rd    = rd;
        issue_lat   = lat;
        issue_var   = isvar;
    endtask

    initial begin
        step();
        step();
        mid();
        chk("reset_stall", 32'(stall), 0);
        chk("reset_mask", pending_mask, 0);
        chk("reset_var_busy", 32'(var_busy), 0);
        step();
        rst = 1'b0;
        step();

        // x5 lat=2, reader of x5 stalls exactly two cycles
        set_issue(1, 5, 2, 0);
        rs1 = 5; rs1_used = 1;
        mid();
        chk("lat2_issue_cycle_stall", 32'(stall), 0);
        step();
        set_issue(0, 0, 0, 0);
        mid();
        chk("lat2_stall_n1", 32'(stall), 1);
        chk("lat2_mask5_n1", 32'(pending_mask[5]), 1);
        step();
        mid();
        chk("lat2_stall_n2", 32'(stall), 1);
        step();
        mid();
        chk("lat2_stall_n3", 32'(stall), 0);
        chk("lat2_mask5_n3", 32'(pending_mask[5]), 0);
        step();
        rs1_used = 0;

        // x0 never gets an entry
        set_issue(1, 0, 3, 0);
        rs2 = 0; rs2_used = 1;
        step();
        set_issue(0, 0, 0, 0);
        mid();
        chk("x0_mask", pending_mask, 0);
        chk("x0_stall", 32'(stall), 0);
        step();
        rs2_used = 0;

        // variable-latency x7 blocks a second variable issue until completion
        set_issue(1, 7, 5, 1);
        step();
        set_issue(1, 10, 0, 1);
        mid();
        chk("var_busy_x7", 32'(var_busy), 1);
        chk("var_mask7", 32'(pending_mask[7]), 1);
        chk("var_second_stall", 32'(stall), 1);
        cmpl_valid = 1; cmpl_rd = 7;
        step();
        cmpl_valid = 0;
        mid();
        chk("var_cmpl_busy", 32'(var_busy), 0);
        chk("var_cmpl_stall", 32'(stall), 0);
        chk("var_cmpl_mask7", 32'(pending_mask[7]), 0);
        step();
        set_issue(0, 0, 0, 0);
        mid();
        chk("var_x10_busy", 32'(var_busy), 1);
        cmpl_valid = 1; cmpl_rd = 3;
        step();
        cmpl_valid = 1; cmpl_rd = 10;
        mid();
        chk("var_wrong_cmpl_busy", 32'(var_busy), 1);
        step();
        cmpl_valid = 0;
        mid();
        chk("var_x10_cmpl", 32'(var_busy), 0);
        step();

        // WAW: lat=0 supersedes a pending lat=4 write
        set_issue(1, 9, 4, 0);
        step();
        set_issue(0, 0, 0, 0);
        step();
        set_issue(1, 9, 0, 0);
        step();
        set_issue(0, 0, 0, 0);
        rs1 = 9; rs1_used = 1;
        mid();
        chk("waw_lat0_mask9", 32'(pending_mask[9]), 0);
        chk("waw_lat0_stall", 32'(stall), 0);
        step();
        rs1_used = 0;

        // WAW: issue of lat=1 wins over the decrement of lat=3
        set_issue(1, 9, 3, 0);
        step();
        set_issue(1, 9, 1, 0);
        step();
        set_issue(0, 0, 0, 0);
        mid();
        chk("waw_issue_wins_p1", 32'(pending_mask[9]), 1);
        step();
        mid();
        chk("waw_issue_wins_p2", 32'(pending_mask[9]), 0);
        step();

        // flush drops fixed and var pend, keeps var slot, ignores issue
        set_issue(1, 3, 3, 0);
        step();
        set_issue(1, 8, 0, 1);
        step();
        set_issue(1, 12, 2, 0);
        flush = 1;
        step();
        flush = 0;
        set_issue(0, 0, 0, 0);
        mid();
        chk("flush_mask3", 32'(pending_mask[3]), 0);
        chk("flush_mask8", 32'(pending_mask[8]), 0);
        chk("flush_mask12", 32'(pending_mask[12]), 0);
        chk("flush_var_busy", 32'(var_busy), 1);
        cmpl_valid = 1; cmpl_rd = 8;
        step();
        cmpl_valid = 0;
        mid();
        chk("flush_cmpl_busy", 32'(var_busy), 0);
        step();

        // async reset mid-countdown with a var write outstanding
        set_issue(1, 4, 0, 1);
        step();
        set_issue(1, 6, 5, 0);
        step();
        set_issue(0, 0, 0, 0);
        rs1 = 6; rs1_used = 1;
        mid();
        chk("pre_reset_stall", 32'(stall), 1);
        chk("pre_reset_busy", 32'(var_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_stall", 32'(stall), 0);
        chk("async_reset_mask", pending_mask, 0);
        chk("async_reset_busy", 32'(var_busy), 0);
        step();
        rst = 1'b0;
        step();
        mid();
        chk("post_reset_stall", 32'(stall), 0);
        chk("post_reset_mask", pending_mask, 0);
        chk("post_reset_busy", 32'(var_busy), 0);
        step();
        rs1_used = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
